// File: rtl/tqvp_byte_bus_initiator_pkg.sv
// Shared definitions for the TinyQV byte-peripheral bus initiator.
//   state_e          : FSM state encoding (3 bits)
//   DEF_*_ADDR       : default register map of the byte peripherals
//   DEF_TIMEOUT      : default number of status-poll cycles before giving up
package tqvp_byte_bus_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_POLL   = 3'd2,
        ST_READ_H = 3'd3,
        ST_READ_L = 3'd4,
        ST_OUT    = 3'd5
    } state_e;

    localparam logic [3:0] DEF_WR_ADDR   = 4'h0;
    localparam logic [3:0] DEF_RDH_ADDR  = 4'h1;
    localparam logic [3:0] DEF_RDL_ADDR  = 4'h2;
    localparam logic [3:0] DEF_STAT_ADDR = 4'h3;
    localparam int         DEF_TIMEOUT   = 8;

endpackage

// File: rtl/tqvp_byte_bus_initiator_if.sv
// Signal bundle for the initiator: upstream sample stream, downstream
// result stream and the byte-peripheral register bus.
//   master : the initiator's view (drives in_ready, out_*, bus_address,
//            bus_data_write, bus_data_in)
//   slave  : the environment's view (upstream source, downstream sink and
//            the responder peripheral)
interface tqvp_byte_bus_initiator_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  bus_address;
    logic        bus_data_write;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;

    modport master (
        input  in_data, in_valid, out_ready, bus_data_out,
        output in_ready, out_data, out_err, out_valid,
               bus_address, bus_data_write, bus_data_in
    );

    modport slave (
        output in_data, in_valid, out_ready, bus_data_out,
        input  in_ready, out_data, out_err, out_valid,
               bus_address, bus_data_write, bus_data_in
    );
endinterface

// File: rtl/tqvp_byte_bus_initiator.sv
// Byte-bus initiator: writes each upstream sample to a responder's data
// register, polls its status flag, reads back the 16-bit result (MSB then
// LSB) and offers it downstream. A status poll that runs TIMEOUT cycles
// without seeing the flag yields result 0 with out_err set.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : master modport (sample in, result out, register bus)
//   busy        : FSM is not idle
//   done_count  : results accepted downstream, wraps at 256
module tqvp_byte_bus_initiator
    import tqvp_byte_bus_initiator_pkg::*;
#(
    parameter logic [3:0] WR_ADDR   = DEF_WR_ADDR,
    parameter logic [3:0] RDH_ADDR  = DEF_RDH_ADDR,
    parameter logic [3:0] RDL_ADDR  = DEF_RDL_ADDR,
    parameter logic [3:0] STAT_ADDR = DEF_STAT_ADDR,
    parameter int         TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             rst,
    tqvp_byte_bus_initiator_if.master        bus,
    output logic                             busy,
    output logic [7:0]                       done_count
);

    state_e      state, state_nxt;
    logic [7:0]  sample;
    logic [7:0]  timer;
    logic [15:0] result;
    logic        err;

    logic poll_hit, poll_expired;
    assign poll_hit     = bus.bus_data_out[0];
    assign poll_expired = (timer == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.in_valid) state_nxt = ST_WRITE;
            ST_WRITE:  state_nxt = ST_POLL;
            // A ready flag wins over an expiring timer on the last poll cycle.
            ST_POLL:   if (poll_hit)          state_nxt = ST_READ_H;
                       else if (poll_expired) state_nxt = ST_OUT;
            ST_READ_H: state_nxt = ST_READ_L;
            ST_READ_L: state_nxt = ST_OUT;
            ST_OUT:    if (bus.out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample     <= '0;
            timer      <= '0;
            result     <= '0;
            err        <= 1'b0;
            done_count <= '0;
        end else begin
            case (state)
                ST_IDLE:   if (bus.in_valid) sample <= bus.in_data;
                ST_WRITE:  timer <= '0;
                ST_POLL: begin
                    if (!poll_hit) begin
                        if (poll_expired) begin
                            result <= '0;
                            err    <= 1'b1;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                end
                ST_READ_H: result[15:8] <= bus.bus_data_out;
                ST_READ_L: begin
                    result[7:0] <= bus.bus_data_out;
                    err         <= 1'b0;
                end
                ST_OUT:    if (bus.out_ready) done_count <= done_count + 8'd1;
                default:   ;
            endcase
        end
    end

    // All bus and handshake outputs are pure decodes of registered state.
    always_comb begin
        bus.in_ready       = (state == ST_IDLE);
        bus.bus_data_write = (state == ST_WRITE);
        bus.bus_data_in    = (state == ST_WRITE) ? sample : 8'h00;
        bus.out_valid      = (state == ST_OUT);
        bus.out_data       = result;
        bus.out_err        = err;
        busy               = (state != ST_IDLE);
        case (state)
            ST_POLL:   bus.bus_address = STAT_ADDR;
            ST_READ_H: bus.bus_address = RDH_ADDR;
            ST_READ_L: bus.bus_address = RDL_ADDR;
            default:   bus.bus_address = WR_ADDR;
        endcase
    end

endmodule

// File: tb/tb_tqvp_byte_bus_initiator.sv
// Bench for tqvp_byte_bus_initiator with a 4-tap FIR responder (5,10,10,5)
// whose status flag rises a configurable number of cycles after each write.
module tb_tqvp_byte_bus_initiator;
    import tqvp_byte_bus_initiator_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] done_count;
    int tests  = 0;
    int failed = 0;

    tqvp_byte_bus_initiator_if bus();

    tqvp_byte_bus_initiator dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    // ---------------- responder: FIR peripheral ----------------
    int          cfg_lat   = 0;   // extra cycles before the flag rises
    bit          cfg_pulse = 0;   // flag stays high for one cycle only
    logic [7:0]  d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [15:0] r_res = '0;
    logic        flag  = 1'b0;
    logic [7:0]  cnt   = '0;

    always @(posedge clk) begin
        if (bus.bus_data_write) begin
            r_res <= 16'(5*int'(d0) + 10*int'(d1) + 10*int'(d2) + 5*int'(d3));
            d0 <= bus.bus_data_in; d1 <= d0; d2 <= d1; d3 <= d2;
            flag <= (cfg_lat == 0);
            cnt  <= 8'(cfg_lat);
        end else begin
            if (flag && (cfg_pulse || bus.bus_address == DEF_RDL_ADDR)) flag <= 1'b0;
            if (cnt != 0) begin
                cnt <= cnt - 8'd1;
                if (cnt == 8'd1) flag <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.bus_data_out = 8'h00;
        case (bus.bus_address)
            DEF_RDH_ADDR:  bus.bus_data_out = r_res[15:8];
            DEF_RDL_ADDR:  bus.bus_data_out = r_res[7:0];
            DEF_STAT_ADDR: bus.bus_data_out = {7'b0, flag};
            default:       bus.bus_data_out = 8'h00;
        endcase
    end

    // ---------------- bus monitor ----------------
    int   cyc = 0, wr_cnt = 0, dbl_wr = 0, poll_cnt = 0, rdh_cnt = 0, rdl_cnt = 0;
    int   acc_edge = 0, wr_edge = 0, ov_edge = 0, res_n = 0;
    logic prev_wr = 1'b0, prev_ov = 1'b0;
    logic [16:0] res_mem [0:1023];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_valid && bus.in_ready) acc_edge <= cyc;
        if (bus.bus_data_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_edge <= cyc;
            if (prev_wr) dbl_wr <= dbl_wr + 1;
        end
        prev_wr <= bus.bus_data_write;
        if (bus.out_valid && !prev_ov) ov_edge <= cyc;
        prev_ov <= bus.out_valid;
        if (busy && bus.bus_address == DEF_STAT_ADDR) poll_cnt <= poll_cnt + 1;
        if (busy && bus.bus_address == DEF_RDH_ADDR)  rdh_cnt  <= rdh_cnt + 1;
        if (busy && bus.bus_address == DEF_RDL_ADDR)  rdl_cnt  <= rdl_cnt + 1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            res_mem[res_n[9:0]] <= {bus.out_err, bus.out_data};
            res_n <= res_n + 1;
        end
    end

    // ---------------- reference model ----------------
    // Every written sample enters the FIR history; a result is the weighted
    // sum of the four samples written before the current one.
    int hist[$];

    function automatic int fir_model();
        int w[4] = '{5, 10, 10, 5};
        int s = 0;
        for (int i = 0; i < 4; i++)
            if (i < hist.size()) s += w[i] * hist[i];
        return s & 16'hFFFF;
    endfunction

    function automatic void hist_push(input int s);
        hist.push_front(s);
        if (hist.size() > 4) void'(hist.pop_back());
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        tests++;
        failed++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic issue(input logic [7:0] s, input int lat, input bit pulse);
        int n = 0;
        cfg_lat = lat; cfg_pulse = pulse;
        bus.in_data = s; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_to("accept");
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        hist_push(int'(s));
    endtask

    task automatic wait_out(output logic [15:0] d, output logic e);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) fail_to("out_valid");
        d = bus.out_data; e = bus.out_err;
    endtask

    task automatic send(input logic [7:0] s, input int lat, input bit pulse,
                        output logic [15:0] d, output logic e);
        issue(s, lat, pulse);
        wait_out(d, e);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1; @(negedge clk); rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  smp;
        int          lat;
        bit          pulse;
        logic [15:0] exp_d;
        bit          exp_e;
    } vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin : main
        vec_t        tbl[7];
        logic [15:0] d;
        logic        e;
        int          p0, h0, l0, w0, dc, x0, r0, n, exp_i;
        int          exp5[300];

        tbl[0] = '{8'h10, 0, 0, 16'h0000, 0};
        tbl[1] = '{8'h20, 0, 0, 16'h0050, 0};
        tbl[2] = '{8'h30, 0, 0, 16'h0140, 0};
        tbl[3] = '{8'h00, 7, 0, 16'h02D0, 0};   // flag on the last poll cycle
        tbl[4] = '{8'h01, 8, 0, 16'h0000, 1};   // flag one cycle too late
        tbl[5] = '{8'h02, 0, 1, 16'h0285, 0};   // single-cycle flag
        tbl[6] = '{8'hFF, 3, 1, 16'h0104, 0};

        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_in_ready",  int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_write",     int'(bus.bus_data_write), 0);
        chk("rst_addr",      int'(bus.bus_address), int'(DEF_WR_ADDR));
        chk("rst_data_in",   int'(bus.bus_data_in), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_done",      int'(done_count), 0);
        chk("rst_out_data",  int'(bus.out_data), 0);
        chk("rst_out_err",   int'(bus.out_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // table-driven vectors
        for (int i = 0; i < 7; i++) begin
            p0 = poll_cnt; h0 = rdh_cnt; l0 = rdl_cnt;
            send(tbl[i].smp, tbl[i].lat, tbl[i].pulse, d, e);
            chk($sformatf("vec%0d_data", i), int'(d), int'(tbl[i].exp_d));
            chk($sformatf("vec%0d_err", i), int'(e), int'(tbl[i].exp_e));
            chk($sformatf("vec%0d_polls", i), poll_cnt - p0,
                (tbl[i].lat + 1 > 8) ? 8 : tbl[i].lat + 1);
            chk($sformatf("vec%0d_rdh", i), rdh_cnt - h0, tbl[i].exp_e ? 0 : 1);
            chk($sformatf("vec%0d_rdl", i), rdl_cnt - l0, tbl[i].exp_e ? 0 : 1);
            if (i == 0) begin
                chk("strobe_T+1",    wr_edge - acc_edge, 1);
                chk("out_valid_T+5", ov_edge - acc_edge, 5);
            end
            if (i == 2) chk("done_after_3", int'(done_count), 3);
        end

        // status never set: exactly TIMEOUT polls, no result reads
        p0 = poll_cnt; h0 = rdh_cnt; l0 = rdl_cnt;
        send(8'h5A, 250, 0, d, e);
        chk("tmo_polls", poll_cnt - p0, 8);
        chk("tmo_rdh",   rdh_cnt - h0, 0);
        chk("tmo_rdl",   rdl_cnt - l0, 0);
        chk("tmo_data",  int'(d), 0);
        chk("tmo_err",   int'(e), 1);

        // downstream back-pressure
        bus.out_ready = 1'b0;
        exp_i = fir_model();
        issue(8'h33, 1, 0);
        wait_out(d, e);
        w0 = wr_cnt; dc = int'(done_count);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_data",     int'(bus.out_data), exp_i);
            chk("bp_valid",    int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
        end
        chk("bp_no_writes", wr_cnt - w0, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_inc", int'(done_count), (dc + 1) & 8'hFF);
        chk("bp_idle",     int'(busy), 0);

        // randomized transactions against the model
        for (int k = 0; k < 40; k++) begin
            logic [7:0] s;
            int lat;
            bit pl;
            s   = 8'($urandom_range(0, 255));
            lat = $urandom_range(0, 10);
            pl  = 1'($urandom_range(0, 1));
            exp_i = (lat + 1 <= 8) ? fir_model() : 0;
            send(s, lat, pl, d, e);
            chk($sformatf("rnd%0d_data", k), int'(d), exp_i);
            chk($sformatf("rnd%0d_err", k), int'(e), (lat + 1 <= 8) ? 0 : 1);
        end

        // reset while polling
        cfg_lat = 5; cfg_pulse = 0;
        issue(8'h44, 5, 0);
        n = 0;
        while (bus.bus_address !== DEF_STAT_ADDR && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) fail_to("reach_poll");
        pulse_reset();
        chk("rstp_in_ready", int'(bus.in_ready), 1);
        chk("rstp_write",    int'(bus.bus_data_write), 0);
        chk("rstp_busy",     int'(busy), 0);
        chk("rstp_valid",    int'(bus.out_valid), 0);
        chk("rstp_done",     int'(done_count), 0);
        exp_i = fir_model();
        send(8'h55, 1, 0, d, e);
        chk("rstp_next_data", int'(d), exp_i);
        chk("rstp_next_err",  int'(e), 0);
        chk("rstp_next_done", int'(done_count), 1);

        // 300 back-to-back samples with in_valid held high
        pulse_reset();
        cfg_lat = 0; cfg_pulse = 0;
        w0 = wr_cnt; x0 = dbl_wr; r0 = res_n;
        for (int k = 0; k < 300; k++) begin
            exp5[k] = fir_model();
            hist_push((k * 7 + 3) & 8'hFF);
        end
        bus.in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            bus.in_data = 8'((k * 7 + 3) & 8'hFF);
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) fail_to("stream_accept");
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_to("stream_drain");
        chk("stream_writes",  wr_cnt - w0, 300);
        chk("stream_dbl_wr",  dbl_wr - x0, 0);
        chk("stream_done",    int'(done_count), 44);
        chk("stream_results", res_n - r0, 300);
        for (int k = 0; k < 300; k++)
            chk($sformatf("stream%0d", k), int'(res_mem[(r0 + k) & 1023]), exp5[k]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
